dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters.
  - Port 0: the CPU core load/store port.
  - Port 1: a secondary master, e.g. a program loader or debug access.
- Sits between the requesters and the RAM. Drives RAM MemWrite/MemRead/address/write_data and routes read_data back to the requester that issued the read.
- Arbitration is fixed-priority to port 0, with a starvation counter that forces a port-1 grant after STARVE_MAX consecutive lost cycles.

Parameters:
- ADDR_W, 10, RAM word address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied cycles for port 1 before it is forced to win (legal range 1..15)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- m0_req  input  1  port 0 request, held until granted
- m0_we  input  1  port 0 write (1) / read (0)
- m0_addr  input  ADDR_W  port 0 address
- m0_wdata  input  DATA_W  port 0 write data
- m0_gnt  output  1  port 0 access issued this cycle
- m0_rvalid  output  1  port 0 read data valid
- m0_rdata  output  DATA_W  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- MemWrite  output  1  RAM write strobe
- MemRead  output  1  RAM read strobe
- address  output  ADDR_W  RAM address
- write_data  output  DATA_W  RAM write data
- read_data  input  DATA_W  RAM read data, valid the cycle after MemRead

Behaviour:
- Reset, sampled on CLK rising edge while RST=1:
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, MemWrite, MemRead = 0.
  - m0_rdata, m1_rdata = 0.
  - Starvation counter = 0; rd_pending = 0.
  - Address/write_data outputs are 0 while no grant.
- Reset mid-operation: an in-flight read is dropped. No rvalid is produced after reset deasserts.
- Grant decision is combinational within the cycle.
  - Only m0_req: grant port 0.
  - Only m1_req: grant port 1.
  - Both requesting: grant port 1 only if starve_cnt == STARVE_MAX, otherwise grant port 0.
  - Neither requesting: no grant, MemWrite = MemRead = 0.
- Exactly one gnt per cycle at most; m0_gnt & m1_gnt never both 1.
- RAM drive in the grant cycle:
  - address = granted addr.
  - MemWrite = granted we.
  - MemRead = ~granted we.
  - write_data = granted wdata.
- Write latency: the write completes at the rising edge ending the grant cycle. No response signal; gnt is the completion.
- Read latency is 1 cycle:
  - Grant in cycle N latches rd_pending = 1 and rd_owner = port.
  - In cycle N+1, the owner's rvalid = 1 and its rdata = read_data.
  - rdata holds its last value until the next valid read for that port; only rvalid pulses.
- Back-to-back accesses are fully pipelined: a new grant may be issued in cycle N+1 while cycle N's read data returns. Any mix of ports and read/write is allowed; sustained throughput is 1 access/cycle.
- Starvation counter starve_cnt, 4 bits:
  - Cleared when m1_gnt = 1 or m1_req = 0.
  - Incremented when m1_req = 1 and m1_gnt = 0.
  - Saturates at STARVE_MAX.
- Requesters hold req/we/addr/wdata stable until gnt. The arbiter does not register request inputs, so a change before grant takes effect immediately.
- Read-after-write to the same address from either port returns the new data. Writes commit at the edge, and the RAM read occurs in a later cycle.

Test Plan:
- Reset: assert RST for 2 cycles with both req=1 -> all gnt/rvalid/MemWrite/MemRead = 0. First cycle after release grants port 0.
- Single-port write then read:
  - m0 writes 0xDEADBEEF to addr 0x010 -> m0_gnt=1, MemWrite=1, address=0x010 in that cycle.
  - m0 reads 0x010 -> m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after grant; m1_rvalid stays 0.
- Contention, STARVE_MAX=4: m0 and m1 both request reads continuously.
  - m0 is granted 4 cycles, then m1 is granted on cycle 5.
  - starve_cnt returns to 0; the pattern repeats 4:1.
- Pipelined mixed traffic:
  - m1 reads 0x3FF in cycle N while m0 writes 0x12345678 to 0x000 in cycle N+1.
  - m1_rvalid=1 in cycle N+1 concurrent with MemWrite=1 for m0; no data misrouted.
- m1 drops its request at starve_cnt=3 -> counter clears to 0. On re-request, 4 more denied cycles are needed before m1 is forced to win.
- Reset mid-read: grant an m0 read in cycle N, RST=1 in cycle N+1 -> m0_rvalid stays 0 through and after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU load/store port (0) and a
// secondary master (1); fixed priority to port 0 with starvation relief for port 1.
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              m0_gnt_s;
  logic              m1_gnt_s;
  logic              m0_rvalid_s;
  logic              m1_rvalid_s;
  logic [3:0]        starve_cnt_q;
  logic [3:0]        starve_cnt_d;
  logic              rd_pending_q;
  logic              rd_pending_d;
  logic              rd_owner_q;
  logic              rd_owner_d;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q;
  logic [DATA_W-1:0] m1_rdata_d;

  // Grant decision: port 0 wins ties unless port 1 has lost STARVE_MAX cycles in a row
  always_comb begin
    m0_gnt_s = 1'b0;
    m1_gnt_s = 1'b0;
    if (RST) begin
      m0_gnt_s = 1'b0;
      m1_gnt_s = 1'b0;
    end else if (m0_req && m1_req) begin
      if (starve_cnt_q == STARVE_LIM) begin
        m1_gnt_s = 1'b1;
      end else begin
        m0_gnt_s = 1'b1;
      end
    end else if (m0_req) begin
      m0_gnt_s = 1'b1;
    end else if (m1_req) begin
      m1_gnt_s = 1'b1;
    end else begin
      m0_gnt_s = 1'b0;
      m1_gnt_s = 1'b0;
    end
  end

  // RAM command mux: the granted port drives the RAM, otherwise everything is idle/zero
  always_comb begin
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    address    = '0;
    write_data = '0;
    case ({m1_gnt_s, m0_gnt_s})
      2'b01: begin
        MemWrite   = m0_we;
        MemRead    = ~m0_we;
        address    = m0_addr;
        write_data = m0_wdata;
      end
      2'b10: begin
        MemWrite   = m1_we;
        MemRead    = ~m1_we;
        address    = m1_addr;
        write_data = m1_wdata;
      end
      default: begin
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        address    = '0;
        write_data = '0;
      end
    endcase
  end

  // Read return: a read granted last cycle comes back now; reset drops it
  always_comb begin
    m0_rvalid_s = rd_pending_q & ~rd_owner_q & ~RST;
    m1_rvalid_s = rd_pending_q & rd_owner_q & ~RST;
  end

  // Next-state: read tracking, held read data per port and starvation count
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_pending_d = rd_pending_q;
    rd_owner_d   = rd_owner_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    if (RST) begin
      starve_cnt_d = 4'd0;
      rd_pending_d = 1'b0;
      rd_owner_d   = 1'b0;
      m0_rdata_d   = '0;
      m1_rdata_d   = '0;
    end else begin
      rd_pending_d = (m0_gnt_s & ~m0_we) | (m1_gnt_s & ~m1_we);
      rd_owner_d   = m1_gnt_s;
      if (m0_rvalid_s) begin
        m0_rdata_d = read_data;
      end else begin
        m0_rdata_d = m0_rdata_q;
      end
      if (m1_rvalid_s) begin
        m1_rdata_d = read_data;
      end else begin
        m1_rdata_d = m1_rdata_q;
      end
      if (m1_gnt_s || !m1_req) begin
        starve_cnt_d = 4'd0;
      end else if (starve_cnt_q >= STARVE_LIM) begin
        starve_cnt_d = STARVE_LIM;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    starve_cnt_q <= starve_cnt_d;
    rd_pending_q <= rd_pending_d;
    rd_owner_q   <= rd_owner_d;
    m0_rdata_q   <= m0_rdata_d;
    m1_rdata_q   <= m1_rdata_d;
  end

  // Outputs: rdata shows the returning word in its valid cycle, else the last one held
  always_comb begin
    m0_gnt    = m0_gnt_s;
    m1_gnt    = m1_gnt_s;
    m0_rvalid = m0_rvalid_s;
    m1_rvalid = m1_rvalid_s;
    if (m0_rvalid_s) begin
      m0_rdata = read_data;
    end else begin
      m0_rdata = m0_rdata_q;
    end
    if (m1_rvalid_s) begin
      m1_rdata = read_data;
    end else begin
      m1_rdata = m1_rdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, then random traffic against a
// transaction-level reference model. Includes a synchronous RAM model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] V1 = 32'h12345678;
  localparam logic [31:0] BF = 32'h0BADF00D;

  typedef struct {
    logic          rst;
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
  } in_t;

  typedef struct {
    logic          g0;
    logic          g1;
    logic          v0;
    logic          v1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic          mw;
    logic          mr;
    logic [AW-1:0] addr;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          MemWrite, MemRead;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // reference model state
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  int            denied;
  bit            pend_v;
  int            pend_port;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] hold0, hold1;

  vec_t vq[$];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 CLK = ~CLK;

  // synchronous single-port RAM: read data appears the cycle after MemRead
  always @(posedge CLK) begin
    if (MemWrite) ram[address] <= write_data;
    if (MemRead) read_data <= ram[address];
  end

  function automatic in_t mki(logic rst, logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    in_t i;
    i.rst = rst; i.r0 = r0; i.w0 = w0; i.a0 = a0; i.d0 = d0;
    i.r1 = r1; i.w1 = w1; i.a1 = a1; i.d1 = d1;
    return i;
  endfunction

  function automatic ex_t mke(logic g0, logic g1, logic v0, logic v1, logic [DW-1:0] rd0,
                              logic [DW-1:0] rd1, logic mw, logic mr, logic [AW-1:0] addr);
    ex_t e;
    e.g0 = g0; e.g1 = g1; e.v0 = v0; e.v1 = v1; e.rd0 = rd0; e.rd1 = rd1;
    e.mw = mw; e.mr = mr; e.addr = addr;
    return e;
  endfunction

  task automatic add_vec(input in_t i, input ex_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_ex(input string tag, input ex_t e);
    chk({tag, ".m0_gnt"},    32'(m0_gnt),    32'(e.g0));
    chk({tag, ".m1_gnt"},    32'(m1_gnt),    32'(e.g1));
    chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'(e.v0));
    chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'(e.v1));
    chk({tag, ".m0_rdata"},  m0_rdata,       e.rd0);
    chk({tag, ".m1_rdata"},  m1_rdata,       e.rd1);
    chk({tag, ".MemWrite"},  32'(MemWrite),  32'(e.mw));
    chk({tag, ".MemRead"},   32'(MemRead),   32'(e.mr));
    chk({tag, ".address"},   32'(address),   32'(e.addr));
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, then advance the model.
  task automatic do_cycle(input in_t i, input bit chk_en, input bit has_tab, input ex_t t);
    ex_t           m;
    int            win;
    logic [DW-1:0] mwd;
    @(negedge CLK);
    RST = i.rst;
    m0_req = i.r0; m0_we = i.w0; m0_addr = i.a0; m0_wdata = i.d0;
    m1_req = i.r1; m1_we = i.w1; m1_addr = i.a1; m1_wdata = i.d1;
    #2;
    if (i.rst) win = -1;
    else if (i.r0 && i.r1) win = (denied >= SM) ? 1 : 0;
    else if (i.r0) win = 0;
    else if (i.r1) win = 1;
    else win = -1;
    m.g0 = (win == 0);
    m.g1 = (win == 1);
    m.v0 = !i.rst && pend_v && pend_port == 0;
    m.v1 = !i.rst && pend_v && pend_port == 1;
    m.rd0 = m.v0 ? pend_data : hold0;
    m.rd1 = m.v1 ? pend_data : hold1;
    m.mw = 1'b0; m.mr = 1'b0; m.addr = '0; mwd = '0;
    if (win == 0) begin
      m.mw = i.w0; m.mr = !i.w0; m.addr = i.a0; mwd = i.d0;
    end else if (win == 1) begin
      m.mw = i.w1; m.mr = !i.w1; m.addr = i.a1; mwd = i.d1;
    end
    if (chk_en) begin
      cmp_ex("model", m);
      chk("model.write_data", write_data, mwd);
      if (has_tab) cmp_ex("table", t);
    end
    if (i.rst) begin
      denied = 0; pend_v = 0; hold0 = '0; hold1 = '0;
    end else begin
      hold0 = m.rd0;
      hold1 = m.rd1;
      pend_v = 0;
      if (win >= 0) begin
        if (m.mw) mdl_mem[m.addr] = mwd;
        else begin
          pend_v = 1; pend_port = win; pend_data = mdl_mem[m.addr];
        end
      end
      if (i.r1 && win != 1) denied = (denied < SM) ? denied + 1 : denied;
      else denied = 0;
    end
    cyc++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 10'h3FF;
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t idle;
    in_t both;
    ex_t none;
    in_t ri;
    for (int k = 0; k < (1 << AW); k++) begin
      ram[k] = '0;
      mdl_mem[k] = '0;
    end
    read_data = '0;
    denied = 0; pend_v = 0; pend_port = 0; pend_data = '0; hold0 = '0; hold1 = '0;
    none = mke(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'h000);
    idle = mki(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0);
    both = mki(1'b0, 1'b1, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0);

    // reset with both requesting, then write/read and pipelined mixed traffic
    for (int k = 0; k < 2; k++)
      add_vec(mki(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 1'b1, 1'b0, 10'h006, 32'h0), none);
    add_vec(mki(1'b0, 1'b1, 1'b1, 10'h010, DB, 1'b1, 1'b1, 10'h3FF, CF),
            mke(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'h010));
    add_vec(mki(1'b0, 1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b1, 10'h3FF, CF),
            mke(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 10'h010));
    add_vec(mki(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h3FF, CF),
            mke(1'b0, 1'b1, 1'b1, 1'b0, DB, 32'h0, 1'b1, 1'b0, 10'h3FF));
    add_vec(mki(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h3FF, 32'h0),
            mke(1'b0, 1'b1, 1'b0, 1'b0, DB, 32'h0, 1'b0, 1'b1, 10'h3FF));
    add_vec(mki(1'b0, 1'b1, 1'b1, 10'h000, V1, 1'b0, 1'b0, 10'h000, 32'h0),
            mke(1'b1, 1'b0, 1'b0, 1'b1, DB, CF, 1'b1, 1'b0, 10'h000));
    // contention: 4 grants to port 0, then forced grant to port 1
    add_vec(both, mke(1'b1, 1'b0, 1'b0, 1'b0, DB, CF, 1'b0, 1'b1, 10'h000));
    for (int k = 0; k < 3; k++)
      add_vec(both, mke(1'b1, 1'b0, 1'b1, 1'b0, V1, CF, 1'b0, 1'b1, 10'h000));
    add_vec(both, mke(1'b0, 1'b1, 1'b1, 1'b0, V1, CF, 1'b0, 1'b1, 10'h010));
    add_vec(both, mke(1'b1, 1'b0, 1'b0, 1'b1, V1, DB, 1'b0, 1'b1, 10'h000));
    for (int k = 0; k < 2; k++)
      add_vec(both, mke(1'b1, 1'b0, 1'b1, 1'b0, V1, DB, 1'b0, 1'b1, 10'h000));
    // port 1 drops at count 3: needs 4 fresh losses before winning again
    add_vec(mki(1'b0, 1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0),
            mke(1'b1, 1'b0, 1'b1, 1'b0, V1, DB, 1'b0, 1'b1, 10'h000));
    for (int k = 0; k < 4; k++)
      add_vec(both, mke(1'b1, 1'b0, 1'b1, 1'b0, V1, DB, 1'b0, 1'b1, 10'h000));
    add_vec(both, mke(1'b0, 1'b1, 1'b1, 1'b0, V1, DB, 1'b0, 1'b1, 10'h010));
    add_vec(mki(1'b0, 1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0),
            mke(1'b1, 1'b0, 1'b0, 1'b1, V1, DB, 1'b0, 1'b1, 10'h000));
    // reset in the cycle after a read grant drops the return
    add_vec(mki(1'b0, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0),
            mke(1'b1, 1'b0, 1'b1, 1'b0, V1, DB, 1'b0, 1'b1, 10'h010));
    add_vec(mki(1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0),
            mke(1'b0, 1'b0, 1'b0, 1'b0, V1, DB, 1'b0, 1'b0, 10'h000));
    add_vec(idle, none);
    add_vec(mki(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h3FF, BF),
            mke(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'h3FF));

    // unchecked power-on reset cycle
    do_cycle(mki(1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0), 1'b0, 1'b0, none);
    foreach (vq[k]) do_cycle(vq[k].i, 1'b1, 1'b1, vq[k].e);

    for (int k = 0; k < 1000; k++) begin
      ri.rst = ($urandom_range(0, 59) == 0);
      ri.r0  = ($urandom_range(0, 9) < 7);
      ri.w0  = 1'($urandom_range(0, 1));
      ri.a0  = rand_addr();
      ri.d0  = $urandom();
      ri.r1  = ($urandom_range(0, 9) < 8);
      ri.w1  = 1'($urandom_range(0, 1));
      ri.a1  = rand_addr();
      ri.d1  = $urandom();
      do_cycle(ri, 1'b1, 1'b0, none);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
